step_generator: RTL
===================

# step_generator

Converts a requested absolute count value into a train of single-cycle `up_o`/`down_o` step pulses that drive a modulo up/down counter (wrap 0..MAX_VAL_P) from its current value to the target along the shortest wrap-aware path. It keeps a shadow position that matches the driven counter, accepts targets over a valid/ready handshake, and spaces steps by a programmable gap. Its outputs connect directly to the counter's `up_i`/`down_i`/`en_i`. Use it for scan-position and line-index control in the filter pipeline.

## Interface
- `WIDTH_P`, 32, width of position, target and distance datapath.
- `MAX_VAL_P`, 128, wrap value; position range is 0..MAX_VAL_P, modulus M = MAX_VAL_P+1; must be < 2^WIDTH_P.
- `DIV_WIDTH_P`, 8, width of step-gap field.
- `clk_i` in 1: single clock; all logic is on posedge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `target_i` in WIDTH_P: requested absolute position.
- `div_i` in DIV_WIDTH_P: idle cycles between consecutive steps; 0 = one step per cycle.
- `valid_i` in 1: target_i/div_i valid.
- `ready_o` out 1: block accepts a request.
- `up_o` out 1: one-cycle increment pulse.
- `down_o` out 1: one-cycle decrement pulse.
- `pos_o` out WIDTH_P: shadow position; includes the effect of every step already pulsed.
- `busy_o` out 1: request in progress.
- `done_o` out 1: one-cycle pulse when a request completes.

## Operation
- FSM states: IDLE, PLAN, STEP, GAP.
- IDLE: `ready_o`=1. On `valid_i && ready_o`, register tgt = min(target_i, MAX_VAL_P) and div = div_i, then go to PLAN. Targets above MAX_VAL_P saturate.
- PLAN: fwd = (tgt − pos) mod M, computed in WIDTH_P+1 bits; back = M − fwd.
  - fwd==0: go to IDLE and pulse `done_o`.
  - Otherwise dir = up if fwd ≤ back (a tie goes up), else down. rem = min(fwd, back). Go to STEP.
- STEP: assert exactly one of `up_o`/`down_o` for one cycle. Update pos with wrap: up from MAX_VAL_P goes to 0; down from 0 goes to MAX_VAL_P. Decrement rem.
  - rem was 1: go to IDLE and pulse `done_o`.
  - Otherwise div==0 → STEP; div>0 → GAP with the gap counter loaded to div.
- GAP: no pulses; decrement the gap counter; at 1 → STEP.
- `up_o` and `down_o` are never both high. Neither is high outside STEP.
- `busy_o` = state ≠ IDLE. `ready_o` = state == IDLE.
- valid_i/target_i/div_i are ignored while busy. A new target takes effect only after `done_o`.

## Timing
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Reset values: `pos_o`=0, `up_o`=0, `down_o`=0, `busy_o`=0, `done_o`=0, `ready_o`=1 (IDLE).
- Asserting rstn_i mid-request immediately clears the state and pulses and sets pos to 0. The downstream counter is reset with the same signal so both stay aligned.
- Accept at edge 0 → PLAN in cycle 1 → first step pulse in cycle 2.
- With gap div, consecutive pulses are div+1 cycles apart.
- `done_o` and `ready_o` rise in the cycle after the last step pulse. For zero distance they rise in cycle 2.
- A new request can be accepted in the same cycle as `done_o`.
- `pos_o` updates on the clock edge that ends each step cycle, matching the counter's `count_o` at the same edge.

## Test plan
- Reset check (WIDTH_P=4, MAX_VAL_P=9): hold rstn_i low, then release → pos_o=0, ready_o=1, up_o/down_o/busy_o/done_o=0.
- Forward path: pos=0, target 3, div 0 → up_o high in cycles 2,3,4; done_o in cycle 5; pos_o=3; a counter model matches pos_o every cycle.
- Wrap down: pos=1, target 8 (fwd 7, back 3) → 3 down pulses; pos sequence 0, 9, 8; done_o pulses. Tie case: pos=0, target 5 → 5 up pulses.
- Zero distance and clamp:
  - pos=4, target 4 → no pulses; done_o in cycle 2.
  - pos=0, target 15 → clamps to 9; one down_o; pos=9.
- Gap spacing: pos=0, target 2, div 2 → up_o in cycles 2 and 5 only; done_o in cycle 6; valid_i asserted mid-request is not accepted (ready_o=0).
- Reset mid-operation: assert rstn_i during GAP of a 5-step request → outputs return to reset values asynchronously; after release, target 1 completes normally with one up pulse.

Source files
------------

// File: rtl/step_generator.sv
// Step generator: walks a wrap-around up/down counter from its current value to a
// requested target along the shortest path, one spaced pulse at a time.
//
// state | meaning
// IDLE  | ready for a request; done pulse shows here after completion
// PLAN  | compute direction and remaining step count from shadow position
// STEP  | emit one up/down pulse and advance the shadow position
// GAP   | idle cycles between steps, counted down from the gap setting
module step_generator #(
    parameter int WIDTH_P     = 32,
    parameter int MAX_VAL_P   = 128,
    parameter int DIV_WIDTH_P = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [WIDTH_P-1:0]     target_i,
    input  logic [DIV_WIDTH_P-1:0] div_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   up_o,
    output logic                   down_o,
    output logic [WIDTH_P-1:0]     pos_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [WIDTH_P-1:0]     MAX_POS = WIDTH_P'(MAX_VAL_P);
    localparam logic [WIDTH_P:0]       MODULUS = (WIDTH_P+1)'(MAX_VAL_P + 1);
    localparam logic [WIDTH_P-1:0]     ONE     = WIDTH_P'(1);
    localparam logic [DIV_WIDTH_P-1:0] GAP_ONE = DIV_WIDTH_P'(1);

    typedef enum logic [1:0] {IDLE, PLAN, STEP, GAP} state_t;

    state_t                 state, state_nxt;
    logic [WIDTH_P-1:0]     tgt, tgt_nxt;
    logic [DIV_WIDTH_P-1:0] div, div_nxt;
    logic [DIV_WIDTH_P-1:0] gap_cnt, gap_cnt_nxt;
    logic [WIDTH_P-1:0]     pos, pos_nxt;
    logic [WIDTH_P-1:0]     rem, rem_nxt;
    logic                   dir_up, dir_up_nxt;
    logic                   done, done_nxt;

    logic [WIDTH_P:0]       fwd, back;
    logic [WIDTH_P-1:0]     pos_inc, pos_dec;

    // Distances use one extra bit so tgt + MODULUS cannot overflow.
    always_comb begin
        fwd = '0;
        if ({1'b0, tgt} >= {1'b0, pos}) begin
            fwd = {1'b0, tgt} - {1'b0, pos};
        end else begin
            fwd = {1'b0, tgt} + MODULUS - {1'b0, pos};
        end
        back    = MODULUS - fwd;
        pos_inc = (pos == MAX_POS) ? '0 : pos + ONE;
        pos_dec = (pos == '0) ? MAX_POS : pos - ONE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tgt_nxt     = tgt;
        div_nxt     = div;
        gap_cnt_nxt = gap_cnt;
        pos_nxt     = pos;
        rem_nxt     = rem;
        dir_up_nxt  = dir_up;
        done_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid_i) begin
                    tgt_nxt   = (target_i > MAX_POS) ? MAX_POS : target_i;
                    div_nxt   = div_i;
                    state_nxt = PLAN;
                end
            end
            PLAN: begin
                if (fwd == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (fwd <= back) begin
                    dir_up_nxt = 1'b1;
                    rem_nxt    = fwd[WIDTH_P-1:0];
                    state_nxt  = STEP;
                end else begin
                    dir_up_nxt = 1'b0;
                    rem_nxt    = back[WIDTH_P-1:0];
                    state_nxt  = STEP;
                end
            end
            STEP: begin
                pos_nxt = dir_up ? pos_inc : pos_dec;
                rem_nxt = rem - ONE;
                if (rem == ONE) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (div == '0) begin
                    state_nxt = STEP;
                end else begin
                    gap_cnt_nxt = div;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - GAP_ONE;
                if (gap_cnt == GAP_ONE) begin
                    state_nxt = STEP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgt     <= '0;
            div     <= '0;
            gap_cnt <= '0;
            pos     <= '0;
            rem     <= '0;
            dir_up  <= 1'b1;
            done    <= 1'b0;
        end else begin
            tgt     <= tgt_nxt;
            div     <= div_nxt;
            gap_cnt <= gap_cnt_nxt;
            pos     <= pos_nxt;
            rem     <= rem_nxt;
            dir_up  <= dir_up_nxt;
            done    <= done_nxt;
        end
    end

    // Pulses decode straight from the registered state so they clear with reset.
    assign up_o    = (state == STEP) && dir_up;
    assign down_o  = (state == STEP) && !dir_up;
    assign ready_o = (state == IDLE);
    assign busy_o  = (state != IDLE);
    assign done_o  = done;
    assign pos_o   = pos;

endmodule
